// File: rtl/input_module.sv
// input_module
//   Buffers host beats in a small FIFO and replays them as an AXI-Stream
//   master toward the NoC. Packets longer than MAXLEN beats are split, and
//   every beat of a packet carries the destination of its first beat.
//
// Ports
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   WR_VALID/WR_READY    host beat handshake (WR_READY is registered)
//   WR_DATA/DEST/LAST    host beat payload; WR_DEST matters on first beat only
//   AXIS_M_*             registered AXI-Stream master outputs, TREADY input
//   DONE                 one-cycle pulse after each TLAST handshake
//   PKT_CNT              wrapping count of completed packets
module input_module #(
   parameter int TDATAW = 32,
   parameter int TDESTW = 4,
   parameter int TIDW   = 2,
   parameter int SRC_ID = 0,
   parameter int DEPTH  = 4,
   parameter int MAXLEN = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [TDATAW-1:0] WR_DATA,
   input  logic [TDESTW-1:0] WR_DEST,
   input  logic              WR_LAST,
   output logic              AXIS_M_TVALID,
   input  logic              AXIS_M_TREADY,
   output logic [TDATAW-1:0] AXIS_M_TDATA,
   output logic              AXIS_M_TLAST,
   output logic [TIDW-1:0]   AXIS_M_TID,
   output logic [TDESTW-1:0] AXIS_M_TDEST,
   output logic              DONE,
   output logic [15:0]       PKT_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (MAXLEN > 2) ? $clog2(MAXLEN) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [BW-1:0] BEAT_MAX = BW'(MAXLEN - 1);

   typedef struct packed {
      logic [TDATAW-1:0] data;
      logic [TDESTW-1:0] dest;
      logic              last;
   } entry_t;

   typedef enum logic {IDLE, IN_PKT} state_t;

   entry_t            mem [DEPTH];
   entry_t            head;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_d;
   logic              push, load, is_last, hs_last;
   state_t            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [TDESTW-1:0] dest_q, dest_d, out_dest;

   assign push    = WR_VALID && WR_READY;
   // Output register refills whenever it is empty or being consumed this edge.
   assign load    = (count != '0) && (!AXIS_M_TVALID || AXIS_M_TREADY);
   assign count_d = count + CW'(push) - CW'(load);
   assign head    = mem[rd_ptr];
   assign hs_last = AXIS_M_TVALID && AXIS_M_TREADY && AXIS_M_TLAST;

   assign AXIS_M_TID = TIDW'(SRC_ID);

   // FIFO storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= '{data: WR_DATA, dest: WR_DEST, last: WR_LAST};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         WR_READY <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         count    <= count_d;
         WR_READY <= (count_d < DEPTH_C);
      end
   end

   // Packet framing: a beat is last if the host says so or the packet has
   // reached MAXLEN beats; either way the next load starts fresh in IDLE.
   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      dest_d   = dest_q;
      is_last  = head.last || (beat_q == BEAT_MAX);
      out_dest = (state_q == IDLE) ? head.dest : dest_q;
      if (load) begin
         if (state_q == IDLE) dest_d = head.dest;
         if (is_last) begin
            state_d = IDLE;
            beat_d  = '0;
         end else begin
            state_d = IN_PKT;
            beat_d  = beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         beat_q  <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         dest_q  <= dest_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         AXIS_M_TVALID <= 1'b0;
         AXIS_M_TDATA  <= '0;
         AXIS_M_TLAST  <= 1'b0;
         AXIS_M_TDEST  <= '0;
      end else if (load) begin
         AXIS_M_TVALID <= 1'b1;
         AXIS_M_TDATA  <= head.data;
         AXIS_M_TLAST  <= is_last;
         AXIS_M_TDEST  <= out_dest;
      end else if (AXIS_M_TREADY) begin
         // Consumed with nothing behind it.
         AXIS_M_TVALID <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         DONE    <= 1'b0;
         PKT_CNT <= '0;
      end else begin
         DONE <= hs_last;
         if (hs_last) PKT_CNT <= PKT_CNT + 16'd1;
      end
   end

endmodule

// File: tb/tb_input_module.sv
// tb_input_module
//   Directed stimulus with a scoreboard: expected beats are queued when the
//   host beat is issued, and a negedge monitor pops and compares each AXI-Stream
//   handshake, plus the DONE pulse that must follow a last beat.
module tb_input_module;
   localparam int TDATAW = 32;
   localparam int TDESTW = 5;
   localparam int TIDW   = 2;
   localparam int SRC_ID = 2;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              WR_VALID = 1'b0;
   logic              WR_READY;
   logic [TDATAW-1:0] WR_DATA = '0;
   logic [TDESTW-1:0] WR_DEST = '0;
   logic              WR_LAST = 1'b0;
   logic              AXIS_M_TVALID;
   logic              AXIS_M_TREADY = 1'b0;
   logic [TDATAW-1:0] AXIS_M_TDATA;
   logic              AXIS_M_TLAST;
   logic [TIDW-1:0]   AXIS_M_TID;
   logic [TDESTW-1:0] AXIS_M_TDEST;
   logic              DONE;
   logic [15:0]       PKT_CNT;

   input_module #(.TDATAW(TDATAW), .TDESTW(TDESTW), .TIDW(TIDW), .SRC_ID(SRC_ID),
                  .DEPTH(4), .MAXLEN(16)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
      .WR_DEST(WR_DEST), .WR_LAST(WR_LAST),
      .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
      .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST),
      .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TDEST(AXIS_M_TDEST),
      .DONE(DONE), .PKT_CNT(PKT_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [TDATAW-1:0] data;
      logic [TDESTW-1:0] dest;
      logic              last;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   bit   done_exp = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
   endtask

   task automatic exp_push(input logic [TDATAW-1:0] d, input logic [TDESTW-1:0] dst, input logic l);
      q.push_back('{data: d, dest: dst, last: l});
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present one beat and hold it until the edge that accepts it.
   task automatic wr(input logic [TDATAW-1:0] d, input logic [TDESTW-1:0] dst, input logic l);
      int t = 0;
      WR_VALID = 1'b1; WR_DATA = d; WR_DEST = dst; WR_LAST = l;
      while (!WR_READY && t < 200) begin tick(); t++; end
      if (!WR_READY) begin
         checks++;
         $display("FAIL wr_timeout: WR_READY stayed 0, want 1");
      end
      tick();
      WR_VALID = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 200) begin tick(); t++; end
      if (q.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: %0d beats outstanding, want 0", q.size());
         q.delete();
      end
      tick();
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wr_ready"}, WR_READY, 0);
      chk({tag, "_tvalid"}, AXIS_M_TVALID, 0);
      chk({tag, "_tdata"}, AXIS_M_TDATA, 0);
      chk({tag, "_tlast"}, AXIS_M_TLAST, 0);
      chk({tag, "_tdest"}, AXIS_M_TDEST, 0);
      chk({tag, "_done"}, DONE, 0);
      chk({tag, "_pkt_cnt"}, PKT_CNT, 0);
   endtask

   // Monitor: inputs only change 1 time unit after posedge, so values seen
   // at negedge are those present at the following rising edge.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (!RST_N) begin
         done_exp <= 1'b0;
      end else begin
         chk("done_pulse", DONE, done_exp);
         if (AXIS_M_TVALID && AXIS_M_TREADY) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_beat: got data 0x%0h, want no beat", AXIS_M_TDATA);
               done_exp <= 1'b0;
            end else begin
               e = q.pop_front();
               chk("tdata", AXIS_M_TDATA, e.data);
               chk("tdest", AXIS_M_TDEST, e.dest);
               chk("tlast", AXIS_M_TLAST, e.last);
               chk("tid", AXIS_M_TID, SRC_ID);
               done_exp <= e.last;
            end
         end else begin
            done_exp <= 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      // Reset state and first edge after release.
      #2;
      chk_reset_outputs("rst");
      tick(); tick();
      RST_N = 1'b1;
      chk("wr_ready_pre_edge", WR_READY, 0);
      tick();
      chk("wr_ready_after_release", WR_READY, 1);

      // Single beat.
      AXIS_M_TREADY = 1'b1;
      exp_push(32'hA5A50001, 5'd3, 1'b1);
      wr(32'hA5A50001, 5'd3, 1'b1);
      chk("single_tvalid_write_edge", AXIS_M_TVALID, 0);
      tick();
      chk("single_tvalid_rise", AXIS_M_TVALID, 1);
      tick();
      chk("single_tvalid_fall", AXIS_M_TVALID, 0);
      chk("single_done", DONE, 1);
      chk("single_pkt_cnt", PKT_CNT, 1);
      drain();

      // Backpressure: 3-beat packet, output stalled.
      AXIS_M_TREADY = 1'b0;
      exp_push(32'hB0000000, 5'd5, 1'b0);
      exp_push(32'hB0000001, 5'd5, 1'b0);
      exp_push(32'hB0000002, 5'd5, 1'b1);
      wr(32'hB0000000, 5'd5, 1'b0);
      wr(32'hB0000001, 5'd6, 1'b0);
      wr(32'hB0000002, 5'd7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_tvalid", AXIS_M_TVALID, 1);
         chk("stall_tdata", AXIS_M_TDATA, 32'hB0000000);
         chk("stall_tdest", AXIS_M_TDEST, 5);
         chk("stall_tlast", AXIS_M_TLAST, 0);
         tick();
      end
      AXIS_M_TREADY = 1'b1;
      drain();
      chk("bp_pkt_cnt", PKT_CNT, 2);

      // Full: 4 FIFO entries plus the output register.
      AXIS_M_TREADY = 1'b0;
      WR_VALID = 1'b1; WR_DEST = 5'd2; WR_LAST = 1'b1;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         WR_DATA = 32'hC0000000 + acc;
         if (WR_READY) begin
            exp_push(32'hC0000000 + acc, 5'd2, 1'b1);
            acc++;
         end
         tick();
      end
      WR_VALID = 1'b0;
      chk("full_accepted", acc, 5);
      chk("full_wr_ready", WR_READY, 0);
      AXIS_M_TREADY = 1'b1;
      tick();
      AXIS_M_TREADY = 1'b0;
      chk("full_wr_ready_after_pulse", WR_READY, 1);
      AXIS_M_TREADY = 1'b1;
      drain();
      chk("full_pkt_cnt", PKT_CNT, 7);

      // Forced split at 16 beats, from a clean reset.
      RST_N = 1'b0; q.delete();
      tick(); tick();
      RST_N = 1'b1;
      tick();
      AXIS_M_TREADY = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         exp_push(32'hD0000000 + i, (i <= 16) ? 5'd1 : 5'd17, (i == 16) || (i == 20));
         wr(32'hD0000000 + i, 5'(i), i == 20);
      end
      drain();
      chk("split_pkt_cnt", PKT_CNT, 2);

      // Reset in the middle of a packet after two beats have gone out.
      AXIS_M_TREADY = 1'b0;
      for (int i = 0; i < 4; i++) exp_push(32'hE0000000 + i, 5'd4, i == 3);
      for (int i = 0; i < 4; i++) wr(32'hE0000000 + i, 5'd4, i == 3);
      AXIS_M_TREADY = 1'b1;
      tick(); tick();
      chk("midpkt_beats_left", q.size(), 2);
      RST_N = 1'b0; q.delete();
      AXIS_M_TREADY = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      tick();
      chk_reset_outputs("midrst_hold");
      RST_N = 1'b1;
      chk("midrst_wr_ready_pre_edge", WR_READY, 0);
      tick();
      chk("midrst_wr_ready_after", WR_READY, 1);
      chk("midrst_tvalid_after", AXIS_M_TVALID, 0);
      AXIS_M_TREADY = 1'b1;
      exp_push(32'hF0000009, 5'd9, 1'b1);
      wr(32'hF0000009, 5'd9, 1'b1);
      drain();
      chk("midrst_pkt_cnt", PKT_CNT, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/input_module.md
INPUT_MODULE -- requirements
Module: input_module

Interface
REQ-001 SHALL have parameter TDATAW, default 32, data width.
REQ-002 SHALL have parameter TDESTW, default 4, destination ID width.
REQ-003 SHALL have parameter TIDW, default 2, source ID width.
REQ-004 SHALL have parameter SRC_ID, default 0, constant driven on AXIS_M_TID.
REQ-005 SHALL have parameter DEPTH, default 4, FIFO entries; power of 2, at least 2.
REQ-006 SHALL have parameter MAXLEN, default 16, max beats per packet; at least 2.
REQ-007 SHALL have port CLK, input, 1, single clock; all logic on rising edge.
REQ-008 SHALL have port RST_N, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have port WR_VALID, input, 1, host beat valid.
REQ-010 SHALL have port WR_READY, output, 1, registered; FIFO can accept a beat.
REQ-011 SHALL have port WR_DATA, input, TDATAW, host beat data.
REQ-012 SHALL have port WR_DEST, input, TDESTW, host destination; used on first beat only.
REQ-013 SHALL have port WR_LAST, input, 1, host end-of-packet marker.
REQ-014 SHALL have ports AXIS_M_TVALID (output, 1), AXIS_M_TREADY (input, 1), AXIS_M_TDATA (output, TDATAW), AXIS_M_TLAST (output, 1), AXIS_M_TID (output, TIDW), AXIS_M_TDEST (output, TDESTW), forming the AXI-Stream master toward the NoC.
REQ-015 SHALL have port DONE, output, 1, one-cycle pulse per completed packet.
REQ-016 SHALL have port PKT_CNT, output, 16, count of completed packets.

Function
REQ-017 SHALL accept a host beat {WR_DATA, WR_DEST, WR_LAST} into the FIFO on any rising edge where WR_VALID and WR_READY are both 1.
REQ-018 SHALL drive WR_READY to 1 for the next cycle only when the FIFO count after the current edge is below DEPTH.
REQ-019 SHALL drive all AXIS_M_* outputs from registers, with no combinational path from inputs.
REQ-020 SHALL load the output register from the FIFO head on an edge where the FIFO is non-empty and (AXIS_M_TVALID==0 or AXIS_M_TREADY==1).
- Result: AXIS_M_TVALID rises on the edge after the host write edge, i.e. 1 cycle write-to-valid latency, with no empty bypass.
REQ-021 SHALL clear AXIS_M_TVALID on an edge where AXIS_M_TREADY==1 and the FIFO is empty.
REQ-022 SHALL hold TVALID, TDATA, TLAST and TDEST stable while TVALID==1 and TREADY==0.
REQ-023 SHALL sustain one beat per cycle while TREADY==1 and the FIFO is non-empty.
REQ-024 SHALL perform a host write and an output load on the same edge when both are enabled; the count is unchanged.
REQ-025 SHALL implement state machine IDLE/IN_PKT, updated only on output loads.
- IDLE loading a non-last beat: go to IN_PKT.
- IN_PKT loading a last beat: go to IDLE.
- IDLE loading a last beat: stay in IDLE.
REQ-026 SHALL, on a load in IDLE, drive TDEST from the entry's dest and latch it; loads in IN_PKT SHALL use the latched dest and ignore the entry's dest.
REQ-027 SHALL keep a beat counter (0..MAXLEN-1) of beats loaded in the current packet, cleared on each last-beat load.
REQ-028 SHALL set TLAST on a load when the entry's last==1 or the beat counter==MAXLEN-1 (forced split); the next beat then starts a new packet in IDLE.
REQ-029 SHALL drive AXIS_M_TID constantly to SRC_ID[TIDW-1:0].
REQ-030 SHALL, on each handshake (TVALID and TREADY) with TLAST==1, increment PKT_CNT by 1 (wrapping 0xFFFF to 0) and pulse DONE high for exactly the following cycle.
REQ-031 SHALL keep DONE high on consecutive cycles for back-to-back TLAST handshakes.

Reset
REQ-032 SHALL, while RST_N==0, force WR_READY, AXIS_M_TVALID, TDATA, TLAST, TDEST, DONE and PKT_CNT to 0, and clear the FIFO pointers, count, state (IDLE), beat counter and latched dest.
REQ-033 SHALL discard any partially sent packet on reset, with no TLAST emitted for it.
REQ-034 SHALL raise WR_READY on the first rising edge after RST_N deasserts.

Verification
REQ-035 SHALL cover a single beat: write 0xA5A50001, dest 3, last 1, with TREADY=1.
- Expected: TVALID for 1 cycle; TDATA=0xA5A50001, TDEST=3, TLAST=1, TID=SRC_ID.
- Expected: DONE pulses on the next cycle and PKT_CNT=1.
REQ-036 SHALL cover backpressure: a 3-beat packet with dests 5, 6, 7 and TREADY=0 for 5 cycles.
- Expected: beat 0 held stable throughout the stall.
- Expected: after release, 3 beats in order, all TDEST=5, TLAST only on beat 3.
REQ-037 SHALL cover full: TREADY=0 with DEPTH=4.
- Expected: exactly 5 beats accepted (4 FIFO + output register), then WR_READY=0.
- Expected: one TREADY pulse gives WR_READY=1 on the next cycle.
REQ-038 SHALL cover forced split: 20 beats with last=0 except beat 20, dests 1..20.
- Expected: beat 16 carries TLAST=1 and TDEST=1.
- Expected: beats 17..20 carry TDEST=17, with TLAST on beat 20; PKT_CNT=2.
REQ-039 SHALL cover reset mid-packet: assert RST_N=0 after 2 of 4 beats are sent.
- Expected: all outputs 0 during reset and WR_READY=1 one edge after release.
- Expected: a following packet with dest 9 emits TDEST=9 and PKT_CNT counts from 0.
